// File: rtl/pipeline_ctrl.sv
// Pipeline buffer control: stall/flush enables, EX forwarding selects,
// exit-syscall RUN/HALT/RESUME sequencing and statistics counters.
module pipeline_ctrl #(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_CODE = 32'd10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [4:0]       id_R1_pos,
    input  logic [4:0]       id_R2_pos,
    input  logic             id_uses_R1,
    input  logic             id_uses_R2,
    input  logic [4:0]       ex_R1_pos,
    input  logic [4:0]       ex_R2_pos,
    input  logic [4:0]       ex_dst,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_dst,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_dst,
    input  logic             wb_reg_write,
    input  logic             wb_syscall,
    input  logic [31:0]      wb_v0,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_en,
    output logic             idex_clr,
    output logic             exmem_en,
    output logic             exmem_clr,
    output logic             memwb_en,
    output logic             memwb_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALT   = 2'd1,
        RESUME = 2'd2
    } state_t;

    state_t state;
    logic   go_q;
    logic   lu;
    logic   br;
    logic   hlt;
    logic   go_rise;
    logic   in_halt;

    assign lu = ex_mem_read && (ex_dst != 5'd0) &&
                ((id_uses_R1 && (ex_dst == id_R1_pos)) ||
                 (id_uses_R2 && (ex_dst == id_R2_pos)));
    assign br      = ex_branch_taken;
    assign hlt     = wb_syscall && (wb_v0 == HALT_CODE);
    assign go_rise = go && !go_q;
    assign in_halt = (state == HALT);

    // State sequencing, go edge history and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            go_q      <= 1'b0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            go_q <= go;
            unique case (state)
                RUN:     if (hlt) state <= HALT;
                HALT:    if (go_rise) state <= RESUME;
                RESUME:  state <= RUN;
                default: state <= RUN;
            endcase
            if (!in_halt) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                stall_cnt <= stall_cnt + CNT_W'(lu && !br);
                flush_cnt <= flush_cnt + CNT_W'(br);
            end
        end
    end

    // Buffer enables/clears: freeze in HALT, otherwise flush beats stall.
    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        ifid_clr  = 1'b0;
        idex_en   = 1'b1;
        idex_clr  = 1'b0;
        exmem_en  = 1'b1;
        exmem_clr = 1'b0;
        memwb_en  = 1'b1;
        memwb_clr = 1'b0;
        halted    = 1'b0;
        if (in_halt) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            halted   = 1'b1;
        end else begin
            if (br) begin
                ifid_clr = 1'b1;
                idex_clr = 1'b1;
            end else if (lu) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_clr = 1'b1;
            end
            // Squash the halting syscall so it cannot fire again.
            if (state == RESUME) memwb_clr = 1'b1;
        end
    end

    // Forwarding selects; the younger MEM result wins over WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_write && mem_dst != 5'd0 && mem_dst == ex_R1_pos)
            fwd_a = 2'b01;
        else if (wb_reg_write && wb_dst != 5'd0 && wb_dst == ex_R1_pos)
            fwd_a = 2'b10;
        if (mem_reg_write && mem_dst != 5'd0 && mem_dst == ex_R2_pos)
            fwd_b = 2'b01;
        else if (wb_reg_write && wb_dst != 5'd0 && wb_dst == ex_R2_pos)
            fwd_b = 2'b10;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go;
    logic [4:0]  id_R1_pos, id_R2_pos, ex_R1_pos, ex_R2_pos;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic        id_uses_R1, id_uses_R2, ex_mem_read, ex_branch_taken;
    logic        mem_reg_write, wb_reg_write, wb_syscall;
    logic [31:0] wb_v0;
    logic        pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
    logic        exmem_en, exmem_clr, memwb_en, memwb_clr, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    // Model: halted flag, one-shot resume flag, go history, counters.
    bit          m_halt;
    bit          m_resume;
    bit          m_goq;
    logic [31:0] m_cyc, m_stall, m_flush;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(32), .HALT_CODE(32'd10)) dut (
        .clk(clk), .rst(rst), .go(go),
        .id_R1_pos(id_R1_pos), .id_R2_pos(id_R2_pos),
        .id_uses_R1(id_uses_R1), .id_uses_R2(id_uses_R2),
        .ex_R1_pos(ex_R1_pos), .ex_R2_pos(ex_R2_pos),
        .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_dst(mem_dst), .mem_reg_write(mem_reg_write),
        .wb_dst(wb_dst), .wb_reg_write(wb_reg_write),
        .wb_syscall(wb_syscall), .wb_v0(wb_v0),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
        .idex_en(idex_en), .idex_clr(idex_clr),
        .exmem_en(exmem_en), .exmem_clr(exmem_clr),
        .memwb_en(memwb_en), .memwb_clr(memwb_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        go = 0; id_R1_pos = 0; id_R2_pos = 0; id_uses_R1 = 0;
        id_uses_R2 = 0; ex_R1_pos = 0; ex_R2_pos = 0; ex_dst = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_dst = 0;
        mem_reg_write = 0; wb_dst = 0; wb_reg_write = 0;
        wb_syscall = 0; wb_v0 = 0;
    endtask

    task automatic model_reset();
        m_halt = 0; m_resume = 0; m_goq = 0;
        m_cyc = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (mem_reg_write && mem_dst != 0 && mem_dst == src) return 2'b01;
        if (wb_reg_write && wb_dst != 0 && wb_dst == src) return 2'b10;
        return 2'b00;
    endfunction

    // One clock: check at negedge, advance model at posedge, return +1.
    task automatic step();
        bit lu, br, hlt, e_pc, e_ifen, e_ifclr, e_idclr, e_mwclr;
        logic [9:0] exp_ctl, obs_ctl;
        @(negedge clk);
        lu = ex_mem_read && ex_dst != 0 &&
             ((id_uses_R1 && ex_dst == id_R1_pos) ||
              (id_uses_R2 && ex_dst == id_R2_pos));
        br  = ex_branch_taken;
        hlt = wb_syscall && wb_v0 == 32'd10;
        if (m_halt) begin
            exp_ctl = 10'b0000000001;
        end else begin
            e_pc    = !(lu && !br);
            e_ifen  = !(lu && !br);
            e_ifclr = br;
            e_idclr = br || lu;
            e_mwclr = m_resume;
            exp_ctl = {e_pc, e_ifen, e_ifclr, 1'b1, e_idclr,
                       1'b1, 1'b0, 1'b1, e_mwclr, 1'b0};
        end
        obs_ctl = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                   exmem_en, exmem_clr, memwb_en, memwb_clr, halted};
        check("ctl", 32'(obs_ctl), 32'(exp_ctl));
        check("fwd_a", 32'(fwd_a), 32'(fwd_model(ex_R1_pos)));
        check("fwd_b", 32'(fwd_b), 32'(fwd_model(ex_R2_pos)));
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        if (!rst) begin
            if (!m_halt) begin
                m_cyc++;
                if (lu && !br) m_stall++;
                if (br) m_flush++;
            end
            if (m_halt) begin
                if (go && !m_goq) begin
                    m_halt = 0;
                    m_resume = 1;
                end
            end else if (m_resume) begin
                m_resume = 0;
            end else if (hlt) begin
                m_halt = 1;
            end
            m_goq = go;
        end
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1;
        model_reset();
        step();
        rst = 0;
    endtask

    logic [31:0] frozen;

    initial begin
        idle();
        model_reset();
        #1;
        pulse_reset();

        // Idle run: five counted cycles, nothing stalled or flushed.
        repeat (5) step();
        check("cyc_after_5", cycle_cnt, 32'd5);
        check("stall_idle", stall_cnt, 32'd0);

        // Load-use on R1.
        ex_mem_read = 1; ex_dst = 8; id_uses_R1 = 1; id_R1_pos = 8;
        #1;
        check("lu_pc_en", 32'(pc_en), 32'd0);
        check("lu_idex_clr", 32'(idex_clr), 32'd1);
        check("lu_exmem_en", 32'(exmem_en), 32'd1);
        step();
        check("lu_stall_cnt", stall_cnt, 32'd1);

        // Load into $zero never stalls.
        ex_dst = 0;
        #1;
        check("lu_zero_pc_en", 32'(pc_en), 32'd1);
        step();

        // Branch overrides load-use.
        ex_dst = 8; ex_branch_taken = 1;
        #1;
        check("br_ifid_clr", 32'(ifid_clr), 32'd1);
        check("br_pc_en", 32'(pc_en), 32'd1);
        step();
        check("br_flush_cnt", flush_cnt, 32'd1);
        check("br_stall_cnt", stall_cnt, 32'd1);
        idle();

        // Forwarding priority.
        mem_reg_write = 1; mem_dst = 5; wb_reg_write = 1; wb_dst = 5;
        ex_R1_pos = 5; ex_R2_pos = 9;
        #1;
        check("fwd_mem", 32'(fwd_a), 32'd1);
        check("fwd_b_none", 32'(fwd_b), 32'd0);
        step();
        mem_reg_write = 0;
        #1;
        check("fwd_wb", 32'(fwd_a), 32'd2);
        step();
        idle();

        // Syscall with non-halting code.
        wb_syscall = 1; wb_v0 = 4;
        step();
        check("no_halt", 32'(halted), 32'd0);

        // Halt, freeze for 10 cycles, then resume.
        wb_v0 = 10;
        step();
        wb_syscall = 0;
        check("halt_entered", 32'(halted), 32'd1);
        frozen = cycle_cnt;
        repeat (10) step();
        check("cyc_frozen", cycle_cnt, frozen);
        go = 1;
        step();
        go = 0;
        check("resume_memwb_clr", 32'(memwb_clr), 32'd1);
        step();
        check("run_again", 32'(halted), 32'd0);

        // go held high across halt entry needs a fresh edge.
        go = 1;
        step();
        wb_syscall = 1; wb_v0 = 10;
        step();
        wb_syscall = 0;
        repeat (3) step();
        check("go_held_stays", 32'(halted), 32'd1);
        go = 0;
        step();
        go = 1;
        step();
        check("go_fresh_edge", 32'(halted), 32'd0);
        go = 0;
        step();

        // Reset in the middle of HALT.
        wb_syscall = 1; wb_v0 = 10;
        step();
        idle();
        repeat (2) step();
        pulse_reset();
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cyc", cycle_cnt, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            go              = ($urandom_range(0, 3) == 0);
            id_R1_pos       = 5'($urandom_range(0, 3));
            id_R2_pos       = 5'($urandom_range(0, 3));
            id_uses_R1      = 1'($urandom);
            id_uses_R2      = 1'($urandom);
            ex_R1_pos       = 5'($urandom_range(0, 3));
            ex_R2_pos       = 5'($urandom_range(0, 3));
            ex_dst          = 5'($urandom_range(0, 3));
            ex_mem_read     = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_dst         = 5'($urandom_range(0, 3));
            mem_reg_write   = 1'($urandom);
            wb_dst          = 5'($urandom_range(0, 3));
            wb_reg_write    = 1'($urandom);
            wb_syscall      = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0, 1:    wb_v0 = 32'd10;
                2:       wb_v0 = 32'd4;
                default: wb_v0 = $urandom;
            endcase
            if (i == 200) pulse_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
